// File: rtl/bitty_pkg.sv
// -----------------------------------------------------------------------------
// bitty_pkg
//  Shared constants for the bitty fetch unit and bitty_core.
//  - DATA_W      : instruction width used by both fetch and core.
//  - ST_*        : 3-bit encoding of the fetch FSM states.
// -----------------------------------------------------------------------------
package bitty_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_EXEC  = 3'd4;

endpackage

// File: rtl/bitty_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// bitty_fetch_unit_if
//  Memory read bus plus core handshake seen by the fetch unit.
//   mem_rd_en    fetch -> mem   one-cycle read request
//   mem_addr     fetch -> mem   read address, held until mem_rd_valid
//   mem_rd_data  mem -> fetch   read data
//   mem_rd_valid mem -> fetch   read data valid
//   instruction  fetch -> core  instruction word
//   run          fetch -> core  one-cycle start pulse
//   done         core -> fetch  completion pulse
//  master = fetch unit side, slave = memory/core side.
// -----------------------------------------------------------------------------
interface bitty_fetch_unit_if
    import bitty_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = bitty_pkg::DATA_W
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] instruction;
    logic              run;
    logic              done;

    modport master (
        output mem_rd_en, mem_addr, instruction, run,
        input  mem_rd_data, mem_rd_valid, done
    );

    modport slave (
        input  mem_rd_en, mem_addr, instruction, run,
        output mem_rd_data, mem_rd_valid, done
    );
endinterface

// File: rtl/bitty_pc.sv
// -----------------------------------------------------------------------------
// bitty_pc
//  Program counter with a pending-jump register.
//   clk, reset  rising-edge clock, synchronous active-low reset
//   inc         instruction completed: take jump target if any, else pc+1
//   load        capture load_val as the pending jump target (last wins)
//   load_val    jump target
//   apply       fetch is starting from idle: take a pending target if any
//   pc          current program counter
//  A load in the same cycle as inc/apply is used directly as the target.
// -----------------------------------------------------------------------------
module bitty_pc #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              apply,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend_val;
    logic              r_pend_vld;
    logic              w_has_tgt;
    logic [ADDR_W-1:0] w_tgt;

    assign w_has_tgt = load | r_pend_vld;
    assign w_tgt     = load ? load_val : r_pend_val;
    assign pc        = r_pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= '0;
            r_pend_val <= '0;
            r_pend_vld <= 1'b0;
        end else if (inc) begin
            // Natural wrap at 2^ADDR_W.
            r_pc       <= w_has_tgt ? w_tgt : r_pc + 1'b1;
            r_pend_vld <= 1'b0;
        end else if (apply) begin
            if (w_has_tgt) r_pc <= w_tgt;
            r_pend_vld <= 1'b0;
        end else if (load) begin
            r_pend_vld <= 1'b1;
            r_pend_val <= load_val;
        end
    end
endmodule

// File: rtl/bitty_fetch_unit.sv
// -----------------------------------------------------------------------------
// bitty_fetch_unit
//  Instruction fetch stage feeding bitty_core. Reads one instruction at pc,
//  pulses run, waits for done, advances pc (or jumps) and repeats while
//  enable=1. A watchdog aborts an instruction whose done never arrives.
//   clk, reset   rising-edge clock, synchronous active-low reset
//   enable       keep fetching; sampled only in IDLE and at EXEC exit
//   bus          memory read bus + core run/done handshake (master side)
//   pc_load      request a jump to pc_load_val
//   pc_load_val  jump target
//   pc           address of the instruction in flight
//   busy         FSM not in IDLE
//   timeout_err  sticky watchdog abort flag, cleared by reset only
// -----------------------------------------------------------------------------
module bitty_fetch_unit
    import bitty_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = bitty_pkg::DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    bitty_fetch_unit_if.master  bus,
    input  logic                pc_load,
    input  logic [ADDR_W-1:0]   pc_load_val,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                timeout_err
);
    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [WD_W-1:0]   r_wd;
    logic [WD_W-1:0]   w_wd_inc;
    logic              r_rd_en;
    logic              r_run;
    logic              r_busy;
    logic              r_err;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] w_pc;
    logic              w_done_exec;
    logic              w_abort;
    logic              w_apply;

    // r_wd holds (EXEC cycles elapsed - 1); w_wd_inc is the current EXEC
    // cycle number, so the abort fires on the TIMEOUT-th cycle without done.
    assign w_wd_inc    = r_wd + 1'b1;
    assign w_done_exec = (r_state == ST_EXEC) && bus.done;
    assign w_abort     = (r_state == ST_EXEC) && !bus.done && (w_wd_inc == WD_LIMIT);
    assign w_apply     = (r_state == ST_IDLE) && (w_state_nxt == ST_FETCH);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable && !r_err) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.mem_rd_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (bus.done)     w_state_nxt = enable ? ST_FETCH : ST_IDLE;
                else if (w_abort) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one reflects the
    // state it belongs to in the same cycle, with no input-to-output path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_wd    <= '0;
            r_rd_en <= 1'b0;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rd_en <= (w_state_nxt == ST_FETCH);
            r_run   <= (w_state_nxt == ST_ISSUE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            if ((r_state == ST_WAIT) && bus.mem_rd_valid) r_instr <= bus.mem_rd_data;
            if (r_state == ST_ISSUE)     r_wd <= '0;
            else if (r_state == ST_EXEC) r_wd <= w_wd_inc;
            if (w_abort) r_err <= 1'b1;
        end
    end

    bitty_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_done_exec),
        .load     (pc_load),
        .load_val (pc_load_val),
        .apply    (w_apply),
        .pc       (w_pc)
    );

    // pc only moves at EXEC exit or IDLE->FETCH, so it is stable as the
    // read address from FETCH through WAIT.
    assign bus.mem_rd_en   = r_rd_en;
    assign bus.mem_addr    = w_pc;
    assign bus.instruction = r_instr;
    assign bus.run         = r_run;
    assign pc              = w_pc;
    assign busy            = r_busy;
    assign timeout_err     = r_err;
endmodule
